video_stream_gen: RTL and testbench



---
 rtl/video_pkg.sv | 19 +
 rtl/video_pattern_lut.sv | 42 ++++
 rtl/video_stream_gen.sv | 189 ++++++++++++++++++
 tb/tb_video_stream_gen.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared encodings and default widths for the video test-pattern source.
// Pattern and FSM state codes are used by the generator and its pattern LUT.
package video_pkg;

   localparam int DEF_DATA_W = 24;
   localparam int DEF_DIM_W  = 12;

   localparam logic [1:0] PAT_HRAMP = 2'd0;
   localparam logic [1:0] PAT_VRAMP = 2'd1;
   localparam logic [1:0] PAT_CHECK = 2'd2;
   localparam logic [1:0] PAT_SOLID = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_GAP    = 2'd2
   } state_t;

endpackage

// File: rtl/video_pattern_lut.sv
// Combinational pixel generator: maps (x, y, pattern, solid colour) to one pixel.
// Each colour component is DATA_W/3 bits; counters are zero-filled or truncated to fit.
module video_pattern_lut
   import video_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DIM_W  = DEF_DIM_W
) (
   input  logic [DIM_W-1:0]  x,
   input  logic [DIM_W-1:0]  y,
   input  logic [1:0]        pattern,
   input  logic [DATA_W-1:0] solid,
   output logic [DATA_W-1:0] pixel
);

   localparam int K = DATA_W / 3;

   logic [K-1:0] x_comp;
   logic [K-1:0] y_comp;
   logic         check_on;

   // Select the pixel value for the requested pattern.
   always_comb begin
      x_comp   = K'(x);
      y_comp   = K'(y);
      check_on = x[4] ^ y[4];
      case (pattern)
         PAT_HRAMP: pixel = DATA_W'({3{x_comp}});
         PAT_VRAMP: pixel = DATA_W'({3{y_comp}});
         PAT_CHECK: begin
            if (check_on) begin
               pixel = {DATA_W{1'b1}};
            end else begin
               pixel = {DATA_W{1'b0}};
            end
         end
         PAT_SOLID: pixel = solid;
         default:   pixel = {DATA_W{1'b0}};
      endcase
   end

endmodule

// File: rtl/video_stream_gen.sv
// AXI4-Stream test-pattern video source: SOF on tuser, EOL on tlast, honours tready.
// Geometry and pattern are latched at every frame start; all outputs are registered.
module video_stream_gen
   import video_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int DIM_W      = DEF_DIM_W,
   parameter int GAP_CYCLES = 16,
   parameter int CNT_W      = 24
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              enable,
   input  logic [DIM_W-1:0]  h_size,
   input  logic [DIM_W-1:0]  v_size,
   input  logic [1:0]        pattern_sel,
   input  logic [DATA_W-1:0] solid_color,
   output logic [DATA_W-1:0] m_axis_video_tdata,
   output logic              m_axis_video_tvalid,
   input  logic              m_axis_video_tready,
   output logic              m_axis_video_tuser,
   output logic              m_axis_video_tlast,
   output logic              busy,
   output logic              frame_done,
   output logic [CNT_W-1:0]  frame_cnt,
   output logic              config_err
);

   localparam int               GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic             HAS_GAP  = (GAP_CYCLES > 0);

   state_t            state;
   logic [DIM_W-1:0]  x;
   logic [DIM_W-1:0]  y;
   logic [GAP_W-1:0]  gap_cnt;
   logic [DIM_W-1:0]  cfg_h;
   logic [DIM_W-1:0]  cfg_v;
   logic [1:0]        cfg_pat;
   logic [DATA_W-1:0] cfg_solid;

   logic              xfer;
   logic              last_x;
   logic              last_y;
   logic              size_ok;
   logic              frame_end;
   logic              gap_end;
   logic              decide;
   logic              launch;
   logic [DIM_W-1:0]  nx;
   logic [DIM_W-1:0]  ny;
   logic [DIM_W-1:0]  lut_x;
   logic [DIM_W-1:0]  lut_y;
   logic [1:0]        lut_pat;
   logic [DATA_W-1:0] lut_solid;
   logic [DATA_W-1:0] lut_pixel;
   logic              next_last;

   // Next-beat coordinates and the frame-start decision; a launch presents pixel (0,0)
   // using the live inputs because the config registers only load on that same edge.
   always_comb begin
      xfer      = m_axis_video_tvalid && m_axis_video_tready;
      last_x    = (x == cfg_h - DIM_W'(1));
      last_y    = (y == cfg_v - DIM_W'(1));
      size_ok   = (h_size != {DIM_W{1'b0}}) && (v_size != {DIM_W{1'b0}});
      frame_end = (state == ST_ACTIVE) && xfer && last_x && last_y;
      gap_end   = (state == ST_GAP) && (gap_cnt == GAP_LAST);
      decide    = (state == ST_IDLE) || gap_end || (frame_end && !HAS_GAP);
      launch    = decide && enable && size_ok;
      if (last_x) begin
         nx = {DIM_W{1'b0}};
         ny = y + DIM_W'(1);
      end else begin
         nx = x + DIM_W'(1);
         ny = y;
      end
      if (launch) begin
         lut_x     = {DIM_W{1'b0}};
         lut_y     = {DIM_W{1'b0}};
         lut_pat   = pattern_sel;
         lut_solid = solid_color;
         next_last = (h_size == DIM_W'(1));
      end else begin
         lut_x     = nx;
         lut_y     = ny;
         lut_pat   = cfg_pat;
         lut_solid = cfg_solid;
         next_last = (nx == cfg_h - DIM_W'(1));
      end
   end

   video_pattern_lut #(
      .DATA_W (DATA_W),
      .DIM_W  (DIM_W)
   ) u_lut (
      .x       (lut_x),
      .y       (lut_y),
      .pattern (lut_pat),
      .solid   (lut_solid),
      .pixel   (lut_pixel)
   );

   // Frame FSM, pixel counters and the registered AXI-Stream output stage.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state               <= ST_IDLE;
         x                   <= {DIM_W{1'b0}};
         y                   <= {DIM_W{1'b0}};
         gap_cnt             <= {GAP_W{1'b0}};
         cfg_h               <= {DIM_W{1'b0}};
         cfg_v               <= {DIM_W{1'b0}};
         cfg_pat             <= 2'd0;
         cfg_solid           <= {DATA_W{1'b0}};
         m_axis_video_tdata  <= {DATA_W{1'b0}};
         m_axis_video_tvalid <= 1'b0;
         m_axis_video_tuser  <= 1'b0;
         m_axis_video_tlast  <= 1'b0;
         busy                <= 1'b0;
         frame_done          <= 1'b0;
         frame_cnt           <= {CNT_W{1'b0}};
         config_err          <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (frame_end) begin
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + CNT_W'(1);
         end
         if (decide && enable && !size_ok) begin
            config_err <= 1'b1;
         end
         if (launch) begin
            state               <= ST_ACTIVE;
            busy                <= 1'b1;
            x                   <= {DIM_W{1'b0}};
            y                   <= {DIM_W{1'b0}};
            cfg_h               <= h_size;
            cfg_v               <= v_size;
            cfg_pat             <= pattern_sel;
            cfg_solid           <= solid_color;
            m_axis_video_tvalid <= 1'b1;
            m_axis_video_tuser  <= 1'b1;
            m_axis_video_tlast  <= next_last;
            m_axis_video_tdata  <= lut_pixel;
         end else begin
            case (state)
               ST_IDLE: begin
                  busy                <= 1'b0;
                  m_axis_video_tvalid <= 1'b0;
               end
               ST_ACTIVE: begin
                  if (frame_end) begin
                     state               <= HAS_GAP ? ST_GAP : ST_IDLE;
                     busy                <= HAS_GAP;
                     gap_cnt             <= {GAP_W{1'b0}};
                     x                   <= {DIM_W{1'b0}};
                     y                   <= {DIM_W{1'b0}};
                     m_axis_video_tvalid <= 1'b0;
                     m_axis_video_tuser  <= 1'b0;
                     m_axis_video_tlast  <= 1'b0;
                     m_axis_video_tdata  <= {DATA_W{1'b0}};
                  end else if (xfer) begin
                     x                  <= nx;
                     y                  <= ny;
                     m_axis_video_tuser <= 1'b0;
                     m_axis_video_tlast <= next_last;
                     m_axis_video_tdata <= lut_pixel;
                  end
               end
               ST_GAP: begin
                  if (gap_end) begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end else begin
                     gap_cnt <= gap_cnt + GAP_W'(1);
                  end
               end
               default: begin
                  state               <= ST_IDLE;
                  busy                <= 1'b0;
                  m_axis_video_tvalid <= 1'b0;
                  m_axis_video_tuser  <= 1'b0;
                  m_axis_video_tlast  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_video_stream_gen.sv
// Self-checking bench for video_stream_gen: directed and randomized frames against
// a frame-list reference model; one instance with a 16-cycle gap, one back-to-back.
module tb_video_stream_gen;

   localparam int DATA_W = 24;
   localparam int DIM_W  = 12;
   localparam int CNT_W  = 24;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              user;
      logic              last;
   } beat_t;

   logic              clk = 1'b0;
   logic              rstn;
   logic              enable;
   logic              tready;
   logic [DIM_W-1:0]  h_size;
   logic [DIM_W-1:0]  v_size;
   logic [1:0]        pattern_sel;
   logic [DATA_W-1:0] solid_color;

   logic [DATA_W-1:0] tdata_a, tdata_b;
   logic              tvalid_a, tvalid_b, tuser_a, tuser_b, tlast_a, tlast_b;
   logic              busy_a, busy_b, done_a, done_b, err_a, err_b;
   logic [CNT_W-1:0]  cnt_a, cnt_b;

   always #5 clk = ~clk;

   video_stream_gen #(.DATA_W(DATA_W), .DIM_W(DIM_W), .GAP_CYCLES(16), .CNT_W(CNT_W)) dut_a (
      .clk(clk), .rstn(rstn), .enable(enable), .h_size(h_size), .v_size(v_size),
      .pattern_sel(pattern_sel), .solid_color(solid_color),
      .m_axis_video_tdata(tdata_a), .m_axis_video_tvalid(tvalid_a),
      .m_axis_video_tready(tready), .m_axis_video_tuser(tuser_a),
      .m_axis_video_tlast(tlast_a), .busy(busy_a), .frame_done(done_a),
      .frame_cnt(cnt_a), .config_err(err_a));

   video_stream_gen #(.DATA_W(DATA_W), .DIM_W(DIM_W), .GAP_CYCLES(0), .CNT_W(CNT_W)) dut_b (
      .clk(clk), .rstn(rstn), .enable(enable), .h_size(h_size), .v_size(v_size),
      .pattern_sel(pattern_sel), .solid_color(solid_color),
      .m_axis_video_tdata(tdata_b), .m_axis_video_tvalid(tvalid_b),
      .m_axis_video_tready(tready), .m_axis_video_tuser(tuser_b),
      .m_axis_video_tlast(tlast_b), .busy(busy_b), .frame_done(done_b),
      .frame_cnt(cnt_b), .config_err(err_b));

   int checks = 0;
   int errors = 0;
   int use_b = 0;
   int beats_seen, lasts_seen, done_seen, bubbles;
   beat_t exp_q[$];

   logic [DATA_W-1:0] obs_data, prev_data;
   logic              obs_valid, obs_user, obs_last, obs_busy, obs_done, obs_err;
   logic [CNT_W-1:0]  obs_cnt;
   logic              prev_valid, prev_rdy, prev_user, prev_last, prev_done;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Reference pixel straight from the pattern definitions (8-bit components).
   function automatic logic [DATA_W-1:0] ref_pixel(input int px, input int py, input int pat,
                                                   input logic [DATA_W-1:0] solid);
      int c;
      c = 0;
      case (pat)
         0: c = px % 256;
         1: c = py % 256;
         2: begin
            if (((px / 16) % 2) != ((py / 16) % 2)) return {DATA_W{1'b1}};
            return {DATA_W{1'b0}};
         end
         default: return solid;
      endcase
      return DATA_W'(c * 65793);
   endfunction

   task automatic push_frame(input int h, input int v, input int pat, input logic [DATA_W-1:0] solid);
      beat_t b;
      for (int py = 0; py < v; py++) begin
         for (int px = 0; px < h; px++) begin
            b.data = ref_pixel(px, py, pat, solid);
            b.user = (px == 0) && (py == 0);
            b.last = (px == h - 1);
            exp_q.push_back(b);
         end
      end
   endtask

   // One cycle: sample at negedge, check hold/beat against the model, then drive tready.
   task automatic cyc(input logic rdy);
      beat_t e;
      @(negedge clk);
      if (use_b != 0) begin
         obs_data = tdata_b; obs_valid = tvalid_b; obs_user = tuser_b; obs_last = tlast_b;
         obs_busy = busy_b; obs_done = done_b; obs_cnt = cnt_b; obs_err = err_b;
      end else begin
         obs_data = tdata_a; obs_valid = tvalid_a; obs_user = tuser_a; obs_last = tlast_a;
         obs_busy = busy_a; obs_done = done_a; obs_cnt = cnt_a; obs_err = err_a;
      end
      if (prev_valid && !prev_rdy)
         chk("hold_stable", {obs_valid, obs_user, obs_last, obs_data},
             {1'b1, prev_user, prev_last, prev_data});
      if (obs_done) begin
         done_seen++;
         chk("done_one_cycle", prev_done, 1'b0);
         chk("frame_cnt_step", obs_cnt, done_seen);
      end
      tready = rdy;
      if (obs_valid && rdy) begin
         if (exp_q.size() == 0) begin
            chk("extra_beat", obs_valid, 1'b0);
         end else begin
            e = exp_q.pop_front();
            chk("beat_data", obs_data, e.data);
            chk("beat_user", obs_user, e.user);
            chk("beat_last", obs_last, e.last);
            beats_seen++;
            if (obs_last) lasts_seen++;
         end
      end
      prev_valid = obs_valid; prev_rdy = rdy; prev_user = obs_user;
      prev_last = obs_last; prev_data = obs_data; prev_done = obs_done;
   endtask

   task automatic run_frame(input int stall_at, input int stall_len, input int drop_at,
                            input int rnd, input int budget);
      int   n = 0;
      int   stalled = 0;
      int   base;
      logic rdy;
      logic started = 1'b0;
      logic changed = 1'b0;
      base = beats_seen;
      while (exp_q.size() > 0 && n < budget) begin
         rdy = 1'b1;
         if (rnd != 0) rdy = ($urandom_range(0, 9) < 7);
         if ((beats_seen - base) == stall_at && stalled < stall_len) begin
            rdy = 1'b0;
            stalled++;
         end
         cyc(rdy);
         if (obs_valid) started = 1'b1;
         else if (started && exp_q.size() > 0) bubbles++;
         if (!rdy && obs_valid && exp_q.size() > 0)
            chk("stall_view", {obs_data, obs_last}, {exp_q[0].data, exp_q[0].last});
         if ((beats_seen - base) >= drop_at) enable = 1'b0;
         if (rnd != 0 && !enable && !changed) begin
            h_size      = DIM_W'($urandom_range(1, 40));
            v_size      = DIM_W'($urandom_range(1, 3));
            pattern_sel = 2'($urandom_range(0, 3));
            solid_color = DATA_W'($urandom);
            changed     = 1'b1;
         end
         n++;
      end
      chk("frame_budget", exp_q.size(), 0);
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      cyc(1'b1);
      while (obs_busy && n < 200) begin
         n++;
         cyc(1'b1);
      end
      chk("idle_budget", obs_busy, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0; enable = 1'b0; tready = 1'b0;
      @(negedge clk);
      chk("reset_a", {tvalid_a, tuser_a, tlast_a, busy_a, done_a, err_a, tdata_a, cnt_a}, 64'd0);
      chk("reset_b", {tvalid_b, tuser_b, tlast_b, busy_b, done_b, err_b, tdata_b, cnt_b}, 64'd0);
      rstn = 1'b1;
      exp_q.delete();
      beats_seen = 0; lasts_seen = 0; done_seen = 0; bubbles = 0;
      prev_valid = 1'b0; prev_rdy = 1'b1; prev_done = 1'b0;
   endtask

   initial begin
      int n;
      int h, v, p;
      logic [DATA_W-1:0] s;
      rstn = 1'b0; enable = 1'b0; tready = 1'b0;
      h_size = 12'd4; v_size = 12'd2; pattern_sel = 2'd0; solid_color = 24'h123456;

      // Single frame, one-cycle enable pulse, then the 16-cycle gap and IDLE.
      use_b = 0;
      do_reset();
      push_frame(4, 2, 0, 24'h123456);
      enable = 1'b1;
      cyc(1'b1);
      chk("sof_latency", {obs_valid, obs_user}, 2'b11);
      enable = 1'b0;
      run_frame(-1, 0, 0, 0, 100);
      wait_idle(n);
      chk("gap_len", n, 16);
      chk("t1_beats", beats_seen, 8);
      chk("t1_lasts", lasts_seen, 2);
      chk("t1_done", done_seen, 1);
      chk("t1_cnt", obs_cnt, 1);

      // Backpressure: tready low for 3 cycles while beat 2 is presented.
      do_reset();
      push_frame(4, 2, 0, 24'h123456);
      enable = 1'b1;
      run_frame(2, 3, 0, 0, 100);
      wait_idle(n);
      chk("t2_beats", beats_seen, 8);
      chk("t2_lasts", lasts_seen, 2);

      // Enable held: relaunch after exactly 16 idle cycles.
      do_reset();
      h_size = 12'd2; v_size = 12'd1; pattern_sel = 2'd3; solid_color = 24'hA5C30F;
      push_frame(2, 1, 3, 24'hA5C30F);
      push_frame(2, 1, 3, 24'hA5C30F);
      enable = 1'b1;
      run_frame(-1, 0, 3, 0, 100);
      chk("relaunch_gap", bubbles, 16);
      wait_idle(n);
      chk("t3a_done", done_seen, 2);

      // Back-to-back instance: h=3, v=2, three frames with no bubbles.
      use_b = 1;
      do_reset();
      h_size = 12'd3; v_size = 12'd2; pattern_sel = 2'd1;
      push_frame(3, 2, 1, 24'h0);
      push_frame(3, 2, 1, 24'h0);
      push_frame(3, 2, 1, 24'h0);
      enable = 1'b1;
      run_frame(-1, 0, 13, 0, 100);
      chk("b2b_bubbles", bubbles, 0);
      wait_idle(n);
      for (int i = 0; i < 10; i++) cyc(1'b1);
      chk("b2b_done", done_seen, 3);
      chk("b2b_cnt", obs_cnt, 3);

      // Enable dropped mid-frame: the frame completes, then IDLE with no more beats.
      use_b = 0;
      do_reset();
      h_size = 12'd4; v_size = 12'd2; pattern_sel = 2'd0;
      push_frame(4, 2, 0, 24'h0);
      enable = 1'b1;
      run_frame(-1, 0, 2, 0, 100);
      wait_idle(n);
      for (int i = 0; i < 10; i++) cyc(1'b1);
      chk("t4_beats", beats_seen, 8);
      chk("t4_cnt", obs_cnt, 1);

      // Zero size: config_err sticky, no output; cleared only by reset.
      do_reset();
      h_size = 12'd0;
      enable = 1'b1;
      for (int i = 0; i < 6; i++) cyc(1'b1);
      chk("cfg_err_set", {obs_err, obs_busy, obs_valid}, 3'b100);
      enable = 1'b0;
      cyc(1'b1);
      chk("cfg_err_sticky", obs_err, 1'b1);
      h_size = 12'd4;
      do_reset();
      push_frame(4, 2, 0, 24'h0);
      enable = 1'b1;
      run_frame(-1, 0, 0, 0, 100);
      wait_idle(n);
      chk("cfg_recover", {obs_err, obs_cnt}, {1'b0, 24'd1});

      // Asynchronous reset in the middle of a frame.
      do_reset();
      push_frame(4, 2, 0, 24'h0);
      enable = 1'b1;
      n = 0;
      while (beats_seen < 6 && n < 50) begin
         cyc(1'b1);
         n++;
      end
      rstn = 1'b0;
      #1;
      chk("rst_async", {tvalid_a, tuser_a, tlast_a, busy_a, done_a, tdata_a, cnt_a}, 64'd0);
      exp_q.delete();
      @(negedge clk);
      rstn = 1'b1;
      beats_seen = 0; done_seen = 0; prev_valid = 1'b0; prev_done = 1'b0;
      push_frame(4, 2, 0, 24'h0);
      run_frame(-1, 0, 0, 0, 100);
      wait_idle(n);
      chk("rst_recover_cnt", obs_cnt, 1);

      // Randomized frames with random backpressure and mid-frame input changes.
      do_reset();
      for (int it = 0; it < 10; it++) begin
         h = $urandom_range(1, 40);
         v = $urandom_range(1, 3);
         if (it == 0) h = 1;
         if (it == 1) v = 1;
         p = $urandom_range(0, 3);
         s = DATA_W'($urandom);
         h_size = DIM_W'(h); v_size = DIM_W'(v); pattern_sel = 2'(p); solid_color = s;
         push_frame(h, v, p, s);
         enable = 1'b1;
         run_frame(-1, 0, 0, 1, h * v * 12 + 50);
         wait_idle(n);
         chk("rand_cnt", obs_cnt, it + 1);
      end
      chk("rand_err", obs_err, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
